fifo_wr_arbiter: RTL
====================

Name: fifo_wr_arbiter

Overview:
- Packet-aware round-robin arbiter that shares one async FIFO write port between N_REQ requesters in the write-clock domain.
- Once a requester is granted, it holds the port until it transfers a beat with req_last, so packets are never interleaved.
- fifo_wr_full back-pressures the granted requester.
- A watchdog ends any packet that exceeds MAX_BEATS beats without req_last.

Parameters:
- N_REQ, 4: number of requesters, 2..16.
- DWIDTH, 64: data width per requester.
- MAX_BEATS, 256: maximum beats per grant before forced release, ≥2.

Ports:
- clk  in  1: write-side clock (drive from the FIFO's wr_clk).
- rst_n  in  1: synchronous reset, active-low.
- req_valid  in  N_REQ: per-requester beat valid.
- req_data  in  N_REQ*DWIDTH: requester i occupies bits [i*DWIDTH +: DWIDTH].
- req_last  in  N_REQ: final beat of packet.
- req_ready  out  N_REQ: per-requester beat accepted.
- fifo_wr_en  out  1: write strobe to FIFO.
- fifo_wr_data  out  DWIDTH: data to FIFO.
- fifo_wr_last  out  1: last flag, for the integrator to pack into the FIFO word.
- fifo_wr_full  in  1: FIFO full.
- grant_valid  out  1: a requester currently owns the port.
- grant_id  out  $clog2(N_REQ): owner index.
- err_overlong  out  1: one-cycle pulse on forced release.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, grant_valid=0, grant_id=0, rr_ptr=0, beat_cnt=0, err_overlong=0.
  - req_ready=0 and fifo_wr_en=0 (combinational from state).
  - A reset mid-packet abandons the packet. No further beats are written. The requester must restart the packet.
- FSM, two states:
  - IDLE: if any req_valid, register grant_id = first index with req_valid set, searching rr_ptr, rr_ptr+1, ... mod N_REQ. Set grant_valid=1, beat_cnt=0, go GRANT. Otherwise stay.
  - GRANT:
    - beat = req_valid[grant_id] & ~fifo_wr_full.
    - req_ready[grant_id] = ~fifo_wr_full. All other req_ready bits are 0.
    - fifo_wr_en = beat. fifo_wr_data = req_data of grant_id. fifo_wr_last = req_last[grant_id] | forced.
    - Each beat increments beat_cnt.
    - forced = (beat_cnt == MAX_BEATS-1) & beat & ~req_last[grant_id].
    - On a beat with req_last, or on a forced beat: next state IDLE, grant_valid=0, rr_ptr = (grant_id+1) mod N_REQ, beat_cnt=0.
    - On a forced beat, err_overlong=1 for the next cycle only.
- Timing:
  - Arbitration bubble: exactly 1 idle cycle between the last beat of one packet and the first beat of the next. Minimum latency from req_valid rising in IDLE to first fifo_wr_en is 1 cycle.
  - A requester that drops req_valid mid-packet keeps the grant. No timeout applies while idle-in-packet.
  - fifo_wr_full high: no beat, no counter change, grant held. Data and last must be held stable by the requester (valid/ready rule).
  - fifo_wr_en is never asserted while fifo_wr_full=1.
- Width rules:
  - beat_cnt is $clog2(MAX_BEATS) bits and never wraps (released at MAX_BEATS-1).
  - rr_ptr wraps from N_REQ-1 to 0. Non-power-of-2 N_REQ uses explicit modulo compare, not bit truncation.
- Simultaneous events:
  - Requests arriving while in GRANT wait.
  - A single-beat packet (valid & last on the first beat) releases after 1 beat.

Test Plan:
- Single requester: req 0 sends a 3-beat packet with last on beat 3. Required: grant_id=0 after 1 cycle; fifo_wr_en on 3 consecutive cycles with data D0..D2; fifo_wr_last on the 3rd beat; then IDLE with rr_ptr=1.
- Fairness: all 4 requesters continuously send 2-beat packets. Required: grant order 0,1,2,3,0; exactly 1 bubble cycle between packets; 16 beats accepted in 23 cycles after the first grant.
- No interleave: req 1 is granted mid-packet while req 0 and req 2 assert valid. Required: req_ready[0] and req_ready[2] stay 0 until req 1's last beat; the next grant goes to 2 (search starts at rr_ptr=2).
- Backpressure: fifo_wr_full=1 for 5 cycles mid-packet. Required: fifo_wr_en=0 and req_ready[g]=0 during the stall; beat_cnt unchanged; the packet resumes with the held data; no beat is lost or duplicated.
- Overlong: MAX_BEATS=4 and req 3 streams without last. Required: 4th beat carries fifo_wr_last=1; err_overlong pulses for 1 cycle; grant released; rr_ptr=0.
- Reset mid-packet: rst_n=0 for 1 cycle during beat 2 of req 2. Required: next cycle grant_valid=0, fifo_wr_en=0, rr_ptr=0; a new request from req 3 with req 0 idle is granted to 3.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Packet-aware round-robin arbiter sharing one FIFO write port between N_REQ requesters.
// A grant is held until a last beat (real or watchdog-forced), so packets never interleave.
module fifo_wr_arbiter #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned DWIDTH    = 64,
  parameter int unsigned MAX_BEATS = 256
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*DWIDTH-1:0]  req_data,
  input  logic [N_REQ-1:0]         req_last,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     fifo_wr_en,
  output logic [DWIDTH-1:0]        fifo_wr_data,
  output logic                     fifo_wr_last,
  input  logic                     fifo_wr_full,
  output logic                     grant_valid,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     err_overlong
);

  localparam int unsigned IdW  = $clog2(N_REQ);
  localparam int unsigned CntW = $clog2(MAX_BEATS);
  localparam logic [IdW-1:0]  LastId  = IdW'(N_REQ - 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(MAX_BEATS - 1);

  typedef enum logic {StIdle, StGrant} state_e;

  state_e          state_q;
  logic [IdW-1:0]  rr_ptr_q;
  logic [CntW-1:0] beat_cnt_q;

  logic [IdW-1:0] pick;
  logic [IdW-1:0] rr_next;
  logic           pick_found;
  logic           in_grant;
  logic           own_valid;
  logic           own_last;
  logic           beat;
  logic           forced;

  // Round-robin search starting at rr_ptr; explicit modulo so non-power-of-2 N_REQ wraps correctly.
  always_comb begin
    int unsigned idx;
    idx        = 0;
    pick       = '0;
    pick_found = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = 32'(rr_ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!pick_found && req_valid[idx[IdW-1:0]]) begin
        pick       = idx[IdW-1:0];
        pick_found = 1'b1;
      end
    end
  end

  assign rr_next   = (grant_id == LastId) ? '0 : grant_id + 1'b1;
  assign in_grant  = (state_q == StGrant);
  assign own_valid = req_valid[grant_id];
  assign own_last  = req_last[grant_id];
  assign beat      = in_grant & own_valid & ~fifo_wr_full;
  assign forced    = beat & ~own_last & (beat_cnt_q == LastCnt);

  assign fifo_wr_en   = beat;
  assign fifo_wr_last = in_grant & (own_last | forced);

  always_comb begin
    fifo_wr_data = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (grant_id == IdW'(k)) fifo_wr_data = req_data[k*DWIDTH +: DWIDTH];
    end
  end

  always_comb begin
    req_ready = '0;
    if (in_grant) req_ready[grant_id] = ~fifo_wr_full;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      grant_valid  <= 1'b0;
      grant_id     <= '0;
      rr_ptr_q     <= '0;
      beat_cnt_q   <= '0;
      err_overlong <= 1'b0;
    end else begin
      err_overlong <= 1'b0;
      case (state_q)
        StIdle: begin
          if (pick_found) begin
            grant_id    <= pick;
            grant_valid <= 1'b1;
            beat_cnt_q  <= '0;
            state_q     <= StGrant;
          end
        end
        StGrant: begin
          if (beat) begin
            if (own_last || forced) begin
              state_q      <= StIdle;
              grant_valid  <= 1'b0;
              rr_ptr_q     <= rr_next;
              beat_cnt_q   <= '0;
              err_overlong <= forced;
            end else begin
              beat_cnt_q <= beat_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
